// File: rtl/fwft_fifo_prog_if.sv
// Stream-side bundle for fwft_fifo_prog: producer/consumer controls and FIFO status.
// Define FWFT_FIFO_ERR_FLAGS_EN to add err_clr, overflow and underflow.
interface fwft_fifo_prog_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
) ();
    logic                  flush;
    logic                  wr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  almost_full;
    logic                  rd;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
`ifdef FWFT_FIFO_ERR_FLAGS_EN
    logic                  err_clr;
    logic                  overflow;
    logic                  underflow;
`endif

    modport master (
        output flush, wr, wr_data, rd,
`ifdef FWFT_FIFO_ERR_FLAGS_EN
        output err_clr,
        input  overflow, underflow,
`endif
        input  full, almost_full, rd_data, empty, almost_empty, count
    );

    modport slave (
        input  flush, wr, wr_data, rd,
`ifdef FWFT_FIFO_ERR_FLAGS_EN
        input  err_clr,
        output overflow, underflow,
`endif
        output full, almost_full, rd_data, empty, almost_empty, count
    );
endinterface

// File: rtl/fwft_fifo_prog.sv
// First-word-fall-through FIFO with registered count, programmable almost flags and flush.
// Define FWFT_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags with err_clr.
module fwft_fifo_prog #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_THRESH  = 2**ADDR_WIDTH - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input logic             clk,
    input logic             arst_n,
    fwft_fifo_prog_if.slave bus
);
    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AfThresh = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AeThresh = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, full_q, almost_empty_q, almost_full_q;
    logic                  wr_acc, rd_acc;

    // Accept decisions use registered flags only, so boundary collisions resolve predictably.
    assign wr_acc = bus.wr & ~full_q & ~bus.flush;
    assign rd_acc = bus.rd & ~empty_q & ~bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
                2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            empty_q        <= (count_d == '0);
            full_q         <= (count_d == DepthCnt);
            almost_empty_q <= (count_d <= AeThresh);
            almost_full_q  <= (count_d >= AfThresh);
        end
    end

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.rd_data      = empty_q ? '0 : mem[rd_ptr_q];
    assign bus.count        = count_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.almost_full  = almost_full_q;

`ifdef FWFT_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A set event beats err_clr in the same cycle; flush discards the request entirely.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (bus.wr & full_q)       overflow_d = 1'b1;
            else if (bus.err_clr)      overflow_d = 1'b0;
            if (bus.rd & empty_q)      underflow_d = 1'b1;
            else if (bus.err_clr)      underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule
